rtl_sadd_arbiter: RTL

Round-robin controller that shares one `rtl_sadd`-style pipelined 32-bit adder blackbox among `N_REQ` requesters. It issues one `ap_start` operation per cycle and tracks the owner of each in-flight operation with a tag pipeline. Each result is routed into a per-requester response slot with a valid/ready handshake. It sits between HLS-generated kernels and the SIMD adder extern, and it owns the adder's clock-enable, reset and start sequencing.

---
 rtl/rtl_sadd_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/rtl_sadd_arbiter.sv
// Round-robin issue controller sharing one pipelined adder among N_REQ requesters.
// A tag pipeline tracks the owner of each in-flight op; results land in per-requester slots.
module rtl_sadd_arbiter #(
   parameter int N_REQ = 4,
   parameter int W     = 32,
   parameter int LAT   = 2
) (
   input  logic               ap_clk,
   input  logic               ap_rst_n,
   input  logic               en,
   input  logic [N_REQ-1:0]   req_vld,
   input  logic [N_REQ*W-1:0] req_a,
   input  logic [N_REQ*W-1:0] req_b,
   output logic [N_REQ-1:0]   req_gnt,
   output logic [N_REQ-1:0]   rsp_vld,
   output logic [N_REQ*W-1:0] rsp_data,
   input  logic [N_REQ-1:0]   rsp_rdy,
   output logic               err,
   output logic               sa_rst,
   output logic               sa_ce,
   output logic               sa_start,
   output logic               sa_continue,
   output logic [W-1:0]       sa_a,
   output logic [W-1:0]       sa_b,
   input  logic               sa_done,
   input  logic [W-1:0]       sa_z
);

   localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [IDW-1:0]            ptr_q, ptr_d;
   logic [N_REQ-1:0]          infl_q, infl_d;
   logic [N_REQ-1:0]          rsp_vld_q, rsp_vld_d;
   logic [N_REQ-1:0][W-1:0]   rsp_data_q;
   logic                      err_q, err_d;
   logic                      srst_q;
   logic [1:0]                srst_cnt_q;
   logic [LAT-1:0]            tag_vld_q;
   logic [LAT-1:0][IDW-1:0]   tag_id_q;

   logic [N_REQ-1:0]          elig;
   logic                      gnt_any;
   logic [IDW-1:0]            gnt_id;
   logic                      last_vld;
   logic [IDW-1:0]            last_id;
   logic                      wb;

   // Busy covers both an op in flight and an undrained slot: one outstanding op per requester.
   always_comb begin : arb
      int unsigned j;
      elig    = req_vld & ~(infl_q | rsp_vld_q);
      gnt_any = 1'b0;
      gnt_id  = '0;
      j       = 0;
      if (en && !srst_q) begin
         for (int k = 0; k < N_REQ; k++) begin
            j = (int'(ptr_q) + k) % N_REQ;
            if (!gnt_any && elig[j]) begin
               gnt_any = 1'b1;
               gnt_id  = IDW'(j);
            end
         end
      end
   end

   always_comb begin
      req_gnt = '0;
      if (gnt_any) req_gnt[gnt_id] = 1'b1;
   end

   assign sa_start    = gnt_any;
   assign sa_a        = gnt_any ? req_a[int'(gnt_id)*W +: W] : '0;
   assign sa_b        = gnt_any ? req_b[int'(gnt_id)*W +: W] : '0;
   assign sa_ce       = en;
   assign sa_continue = 1'b1;
   assign sa_rst      = srst_q;

   assign last_vld = tag_vld_q[LAT-1];
   assign last_id  = tag_id_q[LAT-1];
   assign wb       = en && last_vld;

   always_comb begin
      ptr_d = ptr_q;
      if (gnt_any) ptr_d = (int'(gnt_id) == N_REQ-1) ? '0 : gnt_id + 1'b1;
      infl_d    = infl_q;
      rsp_vld_d = rsp_vld_q & ~rsp_rdy;
      if (wb) begin
         infl_d[last_id]    = 1'b0;
         rsp_vld_d[last_id] = 1'b1;
      end
      if (gnt_any) infl_d[gnt_id] = 1'b1;
      err_d = err_q | (en & ~srst_q & (sa_done ^ last_vld));
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         ptr_q      <= '0;
         infl_q     <= '0;
         rsp_vld_q  <= '0;
         rsp_data_q <= '0;
         err_q      <= 1'b0;
         srst_q     <= 1'b1;
         srst_cnt_q <= 2'd0;
         tag_vld_q  <= '0;
         tag_id_q   <= '0;
      end else begin
         ptr_q     <= ptr_d;
         infl_q    <= infl_d;
         rsp_vld_q <= rsp_vld_d;
         err_q     <= err_d;
         // Adder reset is stretched two cycles past release of ap_rst_n.
         if (srst_q) begin
            srst_cnt_q <= srst_cnt_q + 2'd1;
            if (srst_cnt_q == 2'd1) srst_q <= 1'b0;
         end
         if (srst_q) begin
            tag_vld_q <= '0;
         end else if (en) begin
            tag_vld_q[0] <= gnt_any;
            tag_id_q[0]  <= gnt_id;
            for (int s = 1; s < LAT; s++) begin
               tag_vld_q[s] <= tag_vld_q[s-1];
               tag_id_q[s]  <= tag_id_q[s-1];
            end
         end
         if (wb) rsp_data_q[last_id] <= sa_z;
      end
   end

   assign rsp_vld  = rsp_vld_q;
   assign rsp_data = rsp_data_q;
   assign err      = err_q;

endmodule
